color_bbox_overlay: RTL and testbench
=====================================

# color_bbox_overlay

Downstream stage of the white-balance block in the HDMI video path. It takes the balanced 50-bit pixel pack and classifies each active pixel against a per-channel RGB target window. Per frame, it accumulates the bounding box and hit count of matching pixels and publishes them at the frame boundary for the aim logic. It also draws the previous frame's box outline into the outgoing pack.

## Interface
- H_ACT, 1280, active pixels per line
- V_ACT, 720, active lines per frame
- R_LO / R_HI, 8'd200 / 8'd255, inclusive red window
- G_LO / G_HI, 8'd0 / 8'd60, inclusive green window
- B_LO / B_HI, 8'd0 / 8'd60, inclusive blue window
- MIN_COUNT, 16, minimum hits for a valid box
- BOX_COLOR, 24'h00FF00, outline colour {r,g,b}

Ports:
- clk  input  1  pixel clock; same clock carried in the pack
- rstn  input  1  asynchronous active-low reset
- i_pack  input  50  pixel pack from white balance
- o_pack  output  50  pixel pack to next stage
- o_valid  output  1  latched box meets MIN_COUNT
- o_x_min, o_x_max  output  $clog2(H_ACT)  latched box x bounds
- o_y_min, o_y_max  output  $clog2(V_ACT)  latched box y bounds
- o_count  output  $clog2(H_ACT*V_ACT+1)  latched hit count
- o_frame_done  output  1  one-cycle pulse when results latch

## Operation
- Frame boundary: rising edge of the pack's vsync, detected against a registered copy.
- Hit: de=1 and R_LO<=r<=R_HI and G_LO<=g<=G_HI and B_LO<=b<=B_HI. All comparisons are unsigned and inclusive.
- Accumulator init: x_min=H_ACT-1, x_max=0, y_min=V_ACT-1, y_max=0, count=0.
- On each hit: x_min=min(x_min,x), x_max=max(x_max,x), y_min/y_max likewise, and count+1. The count cannot overflow, because its width covers H_ACT*V_ACT.
- State machine:
  - WAIT_SYNC (reset state): accumulate nothing; go to ACCUM on the first vsync rise. No latch and no o_frame_done on that edge, so the partial frame after reset is discarded.
  - ACCUM: on each vsync rise, latch results, pulse o_frame_done, and reinit the accumulators in the same cycle. Remain in ACCUM.
- Latch:
  - If count>=MIN_COUNT: o_valid=1, bounds=accumulators, o_count=count.
  - Otherwise: o_valid=0, bounds=0, o_count=count.
- Simultaneous hit and vsync rise: the pixel is discarded (reinit wins).
- Overlay: pixel (x,y) with de=1 is on the border when o_valid=1 and either:
  - (x==o_x_min or x==o_x_max) and o_y_min<=y<=o_y_max, or
  - (y==o_y_min or y==o_y_max) and o_x_min<=x<=o_x_max.
  Border pixels get r,g,b=BOX_COLOR; all other pixels pass unchanged.
- The overlay uses the currently latched box, which is the previous frame's result. A latch mid-frame takes effect on the next cycle.
- Reset while in ACCUM: returns to WAIT_SYNC and drops all partial statistics.

## Timing
- o_pack latency is exactly 1 cycle for every field: href, hsync, vsync, de, r, g, b, x, y. The clk field is driven from clk directly.
- Reset values:
  - o_pack: all non-clock fields 0.
  - o_valid=0, all bounds 0, o_count=0, o_frame_done=0.
  - State WAIT_SYNC, accumulators at init.
- o_valid, bounds and o_count update in the cycle after the vsync-rise detect. o_frame_done is high in that same cycle only.
- Throughput: one pixel per clock, no stall.

## Configuration
- COLOR_BBOX_OVERLAY_EN defined: border drawing active as described.
- Undefined: o_pack is i_pack delayed 1 cycle with no modification. Statistics outputs and o_frame_done behave identically in both builds.

## Structure
- Package color_bbox_pkg:
  - bbox_t struct {x_min, x_max, y_min, y_max}, widths set from H_ACT/V_ACT package constants.
  - BBOX_INIT constant.
  - State enum {WAIT_SYNC, ACCUM}.
- Sub-module bbox_accum: hit test, min/max/count accumulation, state machine and latch.
- Top level: hdmi_unpack, bbox_accum, overlay compare and output register, hdmi_pack.

## Test plan
All scenarios use H_ACT=64, V_ACT=48 with default windows.
- Deassert reset mid-frame, then send frames of black pixels: no o_frame_done at the first vsync rise. At the second: pulse, o_valid=0, o_count=0.
- 10x10 block of 24'hFF1010 at x=20..29, y=10..19: at the next latch x_min=20, x_max=29, y_min=10, y_max=19, o_count=100, o_valid=1. In the following frame pixels (20,15) and (25,10) output 24'h00FF00, while (25,15) is unchanged.
- 15 hit pixels with MIN_COUNT=16: o_count=15, o_valid=0, bounds 0, no outline drawn.
- Hits only at (0,0) and (63,47): box 0..63 x 0..47, o_count=2 with MIN_COUNT=2. The outline covers the frame edges.
- Hit asserted in the same cycle as the vsync rise: that pixel is absent from both the ending and the next frame's count.
- Build without COLOR_BBOX_OVERLAY_EN, valid box present: o_pack equals i_pack delayed exactly 1 cycle on every field; statistics still correct.

Source files
------------

// File: rtl/color_bbox_pkg.sv
// color_bbox_pkg: pixel pack layout, colour window, box types and state
// encoding shared by the color_bbox_overlay slice.
package color_bbox_pkg;

    localparam int H_ACT  = 1280;
    localparam int V_ACT  = 720;
    localparam int XW     = $clog2(H_ACT);
    localparam int YW     = $clog2(V_ACT);
    localparam int PACK_W = 50;

    localparam logic [7:0] R_LO = 8'd200;
    localparam logic [7:0] R_HI = 8'd255;
    localparam logic [7:0] G_LO = 8'd0;
    localparam logic [7:0] G_HI = 8'd60;
    localparam logic [7:0] B_LO = 8'd0;
    localparam logic [7:0] B_HI = 8'd60;

    localparam logic [23:0] BOX_COLOR = 24'h00FF00;

    // Pack layout, MSB first: clk href hsync vsync de r g b x y
    typedef struct packed {
        logic          clk;
        logic          href;
        logic          hsync;
        logic          vsync;
        logic          de;
        logic [7:0]    r;
        logic [7:0]    g;
        logic [7:0]    b;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
    } pixel_t;

    typedef struct packed {
        logic [XW-1:0] x_min;
        logic [XW-1:0] x_max;
        logic [YW-1:0] y_min;
        logic [YW-1:0] y_max;
    } bbox_t;

    typedef enum logic {
        WAIT_SYNC,
        ACCUM
    } state_e;

    function automatic bbox_t bbox_init(int h, int v);
        bbox_t bx;
        bx.x_min = XW'(h - 1);
        bx.x_max = '0;
        bx.y_min = YW'(v - 1);
        bx.y_max = '0;
        return bx;
    endfunction

    localparam bbox_t BBOX_INIT = bbox_init(H_ACT, V_ACT);

    function automatic logic in_window(logic [7:0] v, logic [7:0] lo,
                                       logic [7:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    function automatic pixel_t hdmi_unpack(logic [PACK_W-1:0] p);
        return pixel_t'(p);
    endfunction

    function automatic logic [PACK_W-1:0] hdmi_pack(pixel_t p);
        return p;
    endfunction

endpackage

// File: rtl/color_bbox_if.sv
// color_bbox_if: pixel pack in/out plus latched box statistics.
// slave is the overlay block, master is whoever drives the pack.
interface color_bbox_if
    import color_bbox_pkg::*;
#(
    parameter int H_ACT = color_bbox_pkg::H_ACT,
    parameter int V_ACT = color_bbox_pkg::V_ACT
);
    localparam int HW = $clog2(H_ACT);
    localparam int VW = $clog2(V_ACT);
    localparam int CW = $clog2(H_ACT * V_ACT + 1);

    logic [PACK_W-1:0] i_pack;
    logic [PACK_W-1:0] o_pack;
    logic              o_valid;
    logic [HW-1:0]     o_x_min;
    logic [HW-1:0]     o_x_max;
    logic [VW-1:0]     o_y_min;
    logic [VW-1:0]     o_y_max;
    logic [CW-1:0]     o_count;
    logic              o_frame_done;

    modport master (
        output i_pack,
        input  o_pack, o_valid, o_x_min, o_x_max,
        input  o_y_min, o_y_max, o_count, o_frame_done
    );

    modport slave (
        input  i_pack,
        output o_pack, o_valid, o_x_min, o_x_max,
        output o_y_min, o_y_max, o_count, o_frame_done
    );

endinterface

// File: rtl/color_bbox_overlay_bbox_accum.sv
// bbox_accum: per-frame hit test and box/count accumulation, latched on
// each vsync rise once the first full frame has started.
module bbox_accum
    import color_bbox_pkg::*;
#(
    parameter int H_ACT     = color_bbox_pkg::H_ACT,
    parameter int V_ACT     = color_bbox_pkg::V_ACT,
    parameter int MIN_COUNT = 16,
    parameter int CW        = $clog2(H_ACT * V_ACT + 1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          de,
    input  logic          vsync,
    input  logic [7:0]    r,
    input  logic [7:0]    g,
    input  logic [7:0]    b,
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    output logic          valid,
    output bbox_t         box,
    output logic [CW-1:0] count,
    output logic          frame_done
);
    localparam bbox_t         INIT  = bbox_init(H_ACT, V_ACT);
    localparam logic [CW-1:0] MIN_C = CW'(MIN_COUNT);

    state_e        state;
    state_e        state_nx;
    logic          vs_q;
    logic          rise;
    logic          hit;
    logic          latch;
    bbox_t         acc;
    logic [CW-1:0] acc_cnt;

    assign rise = vsync & ~vs_q;
    assign hit  = de && in_window(r, R_LO, R_HI)
               && in_window(g, G_LO, G_HI)
               && in_window(b, B_LO, B_HI);

    always_comb begin
        state_nx = state;
        latch    = 1'b0;
        unique case (state)
            WAIT_SYNC: if (rise) state_nx = ACCUM;
            ACCUM:     latch = rise;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= WAIT_SYNC;
            vs_q  <= 1'b0;
        end else begin
            state <= state_nx;
            vs_q  <= vsync;
        end
    end

    // A hit coinciding with the frame edge is dropped: reinit wins.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc     <= INIT;
            acc_cnt <= '0;
        end else if (rise || state == WAIT_SYNC) begin
            acc     <= INIT;
            acc_cnt <= '0;
        end else if (hit) begin
            if (x < acc.x_min) acc.x_min <= x;
            if (x > acc.x_max) acc.x_max <= x;
            if (y < acc.y_min) acc.y_min <= y;
            if (y > acc.y_max) acc.y_max <= y;
            acc_cnt <= acc_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid      <= 1'b0;
            box        <= '0;
            count      <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= latch;
            if (latch) begin
                valid <= (acc_cnt >= MIN_C);
                box   <= (acc_cnt >= MIN_C) ? acc : '0;
                count <= acc_cnt;
            end
        end
    end

endmodule

// File: rtl/color_bbox_overlay.sv
// color_bbox_overlay: colour-window bounding box statistics with optional
// outline drawing of the previous frame's box (COLOR_BBOX_OVERLAY_EN).
module color_bbox_overlay
    import color_bbox_pkg::*;
#(
    parameter int H_ACT     = color_bbox_pkg::H_ACT,
    parameter int V_ACT     = color_bbox_pkg::V_ACT,
    parameter int MIN_COUNT = 16
) (
    input logic         clk,
    input logic         rstn,
    color_bbox_if.slave bus
);
    localparam int HW = $clog2(H_ACT);
    localparam int VW = $clog2(V_ACT);
    localparam int CW = $clog2(H_ACT * V_ACT + 1);

    pixel_t        px;
    pixel_t        px_nx;
    pixel_t        px_q;
    pixel_t        px_o;
    logic          valid;
    bbox_t         box;
    logic [CW-1:0] count;
    logic          frame_done;
    logic          border;

    assign px = hdmi_unpack(bus.i_pack);

    bbox_accum #(
        .H_ACT     (H_ACT),
        .V_ACT     (V_ACT),
        .MIN_COUNT (MIN_COUNT),
        .CW        (CW)
    ) u_accum (
        .clk        (clk),
        .rstn       (rstn),
        .de         (px.de),
        .vsync      (px.vsync),
        .r          (px.r),
        .g          (px.g),
        .b          (px.b),
        .x          (px.x),
        .y          (px.y),
        .valid      (valid),
        .box        (box),
        .count      (count),
        .frame_done (frame_done)
    );

`ifdef COLOR_BBOX_OVERLAY_EN
    logic on_col;
    logic on_row;

    always_comb begin
        on_col = (px.x == box.x_min || px.x == box.x_max)
              && px.y >= box.y_min && px.y <= box.y_max;
        on_row = (px.y == box.y_min || px.y == box.y_max)
              && px.x >= box.x_min && px.x <= box.x_max;
        border = px.de && valid && (on_col || on_row);
    end
`else
    assign border = 1'b0;
`endif

    always_comb begin
        px_nx = px;
        if (border) {px_nx.r, px_nx.g, px_nx.b} = BOX_COLOR;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) px_q <= '0;
        else       px_q <= px_nx;
    end

    // The pack carries the live pixel clock, not a registered copy.
    always_comb begin
        px_o     = px_q;
        px_o.clk = clk;
    end

    assign bus.o_pack       = hdmi_pack(px_o);
    assign bus.o_valid      = valid;
    assign bus.o_x_min      = box.x_min[HW-1:0];
    assign bus.o_x_max      = box.x_max[HW-1:0];
    assign bus.o_y_min      = box.y_min[VW-1:0];
    assign bus.o_y_max      = box.y_max[VW-1:0];
    assign bus.o_count      = count;
    assign bus.o_frame_done = frame_done;

endmodule

// File: tb/tb_color_bbox_overlay.sv
// Bench for color_bbox_overlay: two instances (MIN_COUNT 16 and 2) on one
// pixel stream, checked every cycle against a frame-level reference model.
`timescale 1ns/1ps
module tb_color_bbox_overlay;

    localparam int H  = 64;
    localparam int V  = 48;
    localparam int HW = 6;
    localparam int VW = 6;
    localparam int CW = 12;

`ifdef COLOR_BBOX_OVERLAY_EN
    localparam bit OVL = 1'b1;
`else
    localparam bit OVL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [49:0] pk = '0;

    always #5 clk = ~clk;

    color_bbox_if #(.H_ACT(H), .V_ACT(V)) bus_a ();
    color_bbox_if #(.H_ACT(H), .V_ACT(V)) bus_b ();

    assign bus_a.i_pack = pk;
    assign bus_b.i_pack = pk;

    color_bbox_overlay #(.H_ACT(H), .V_ACT(V), .MIN_COUNT(16)) dut_a (
        .clk (clk), .rstn (rstn), .bus (bus_a)
    );
    color_bbox_overlay #(.H_ACT(H), .V_ACT(V), .MIN_COUNT(2)) dut_b (
        .clk (clk), .rstn (rstn), .bus (bus_b)
    );

    typedef struct {
        logic [49:0]   pack;
        logic          valid;
        logic [HW-1:0] xmin;
        logic [HW-1:0] xmax;
        logic [VW-1:0] ymin;
        logic [VW-1:0] ymax;
        logic [CW-1:0] cnt;
        logic          fd;
    } exp_t;

    typedef struct {
        int x;
        int y;
    } pt_t;

    exp_t qa[$];
    exp_t qb[$];
    pt_t  hits[$];

    int tests = 0;
    int fails = 0;

    // Reference model state: whether a frame edge has been seen since
    // reset, the hits of the frame in progress, and the published result.
    bit armed = 0;
    bit vs_prev = 0;
    int lv[2], lx0[2], lx1[2], ly0[2], ly1[2];
    int lcnt = 0;
    int minc[2] = '{16, 2};

    function automatic bit on_box(int d, int x, int y);
        bit col, row;
        col = (x == lx0[d] || x == lx1[d]) && y >= ly0[d] && y <= ly1[d];
        row = (y == ly0[d] || y == ly1[d]) && x >= lx0[d] && x <= lx1[d];
        return col || row;
    endfunction

    task automatic model_step();
        exp_t e[2];
        bit vs, de, hit, rise, fd;
        int r, g, b, x, y, n, x0, x1, y0, y1;
        vs = pk[46];
        de = pk[45];
        r  = int'(pk[44:37]);
        g  = int'(pk[36:29]);
        b  = int'(pk[28:21]);
        x  = int'(pk[20:10]);
        y  = int'(pk[9:0]);
        if (!rstn) begin
            armed = 0;
            vs_prev = 0;
            hits.delete();
            lcnt = 0;
            for (int d = 0; d < 2; d++) begin
                lv[d] = 0; lx0[d] = 0; lx1[d] = 0; ly0[d] = 0; ly1[d] = 0;
                e[d].pack = 50'd0;
                e[d].pack[49] = 1'b1;
            end
            fd = 0;
        end else begin
            hit = de && r >= 200 && r <= 255 && g <= 60 && b <= 60;
            for (int d = 0; d < 2; d++) begin
                e[d].pack = pk;
                e[d].pack[49] = 1'b1;
                if (OVL && de && lv[d] == 1 && on_box(d, x, y))
                    e[d].pack[44:21] = 24'h00FF00;
            end
            rise = vs && !vs_prev;
            fd = 0;
            if (rise) begin
                if (armed) begin
                    n = hits.size();
                    x0 = H - 1; x1 = 0; y0 = V - 1; y1 = 0;
                    foreach (hits[i]) begin
                        if (hits[i].x < x0) x0 = hits[i].x;
                        if (hits[i].x > x1) x1 = hits[i].x;
                        if (hits[i].y < y0) y0 = hits[i].y;
                        if (hits[i].y > y1) y1 = hits[i].y;
                    end
                    lcnt = n;
                    for (int d = 0; d < 2; d++) begin
                        lv[d] = (n >= minc[d]) ? 1 : 0;
                        lx0[d] = lv[d] ? x0 : 0;
                        lx1[d] = lv[d] ? x1 : 0;
                        ly0[d] = lv[d] ? y0 : 0;
                        ly1[d] = lv[d] ? y1 : 0;
                    end
                    fd = 1;
                end
                armed = 1;
                hits.delete();
            end else if (armed && hit) begin
                hits.push_back('{x, y});
            end
            vs_prev = vs;
        end
        for (int d = 0; d < 2; d++) begin
            e[d].valid = lv[d][0];
            e[d].xmin = HW'(lx0[d]);
            e[d].xmax = HW'(lx1[d]);
            e[d].ymin = VW'(ly0[d]);
            e[d].ymax = VW'(ly1[d]);
            e[d].cnt = CW'(lcnt);
            e[d].fd = fd;
        end
        qa.push_back(e[0]);
        qb.push_back(e[1]);
    endtask

    always @(posedge clk) model_step();

    task automatic cmp(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 30)
                $display("FAIL %s at %0t: got %h, expected %h",
                         name, $time, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            if (qa.size() > 0) begin
                e = qa.pop_front();
                cmp("a.o_pack", 64'(bus_a.o_pack), 64'(e.pack));
                cmp("a.o_valid", 64'(bus_a.o_valid), 64'(e.valid));
                cmp("a.o_x_min", 64'(bus_a.o_x_min), 64'(e.xmin));
                cmp("a.o_x_max", 64'(bus_a.o_x_max), 64'(e.xmax));
                cmp("a.o_y_min", 64'(bus_a.o_y_min), 64'(e.ymin));
                cmp("a.o_y_max", 64'(bus_a.o_y_max), 64'(e.ymax));
                cmp("a.o_count", 64'(bus_a.o_count), 64'(e.cnt));
                cmp("a.o_frame_done", 64'(bus_a.o_frame_done), 64'(e.fd));
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                cmp("b.o_pack", 64'(bus_b.o_pack), 64'(e.pack));
                cmp("b.o_valid", 64'(bus_b.o_valid), 64'(e.valid));
                cmp("b.o_x_min", 64'(bus_b.o_x_min), 64'(e.xmin));
                cmp("b.o_x_max", 64'(bus_b.o_x_max), 64'(e.xmax));
                cmp("b.o_y_min", 64'(bus_b.o_y_min), 64'(e.ymin));
                cmp("b.o_y_max", 64'(bus_b.o_y_max), 64'(e.ymax));
                cmp("b.o_count", 64'(bus_b.o_count), 64'(e.cnt));
                cmp("b.o_frame_done", 64'(bus_b.o_frame_done), 64'(e.fd));
            end
        end
    end

    function automatic logic [23:0] hit_rgb();
        logic [7:0] r, g, b;
        r = 8'($urandom_range(200, 255));
        g = 8'($urandom_range(0, 60));
        b = 8'($urandom_range(0, 60));
        return {r, g, b};
    endfunction

    // mode 0 black, 1 10x10 block, 2 fifteen hits, 3 corners, 4 random
    function automatic logic [23:0] pix_rgb(int mode, int x, int y);
        logic [23:0] c;
        c = 24'h000000;
        unique case (mode)
            1: if (x >= 20 && x <= 29 && y >= 10 && y <= 19) c = 24'hFF1010;
            2: for (int i = 0; i < 15; i++)
                   if (x == 2 + 3 * i && y == 7 + 9 * (i % 4)) c = hit_rgb();
            3: if ((x == 0 && y == 0) || (x == H - 1 && y == V - 1))
                   c = 24'hC8003C;
            4: c = ($urandom_range(0, 7) == 0) ? hit_rgb() : 24'($urandom);
            default: c = 24'h000000;
        endcase
        return c;
    endfunction

    task automatic put(bit hr, bit hs, bit vs, bit de, logic [23:0] rgb,
                       int x, int y);
        pk = {1'b0, hr, hs, vs, de, rgb, 11'(x), 10'(y)};
        @(posedge clk);
        #1;
    endtask

    task automatic send_lines(int mode, int y0, int y1);
        for (int y = y0; y < y1; y++) begin
            put(0, 1, 0, 0, 24'($urandom), $urandom_range(0, 2047),
                $urandom_range(0, 1023));
            put(0, 0, 0, 0, 24'($urandom), $urandom_range(0, 2047),
                $urandom_range(0, 1023));
            for (int x = 0; x < H; x++)
                put(1, 0, 0, 1, pix_rgb(mode, x, y), x, y);
        end
    endtask

    // vs_hit puts an in-window active pixel on the vsync-rise cycle.
    task automatic send_header(bit vs_hit);
        for (int i = 0; i < 3; i++) begin
            if (vs_hit && i == 0) put(1, 0, 1, 1, hit_rgb(), 5, 5);
            else put(0, 0, 1, 0, 24'($urandom), $urandom_range(0, 2047), 0);
        end
        put(0, 0, 0, 0, 24'h0, 0, 0);
        put(0, 0, 0, 0, 24'h0, 0, 0);
    endtask

    task automatic send_frame(int mode, bit vs_hit);
        send_header(vs_hit);
        send_lines(mode, 0, V);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        send_lines(4, 0, 10);
        rstn = 1'b1;
        send_lines(4, 10, V);
        send_frame(0, 0);
        send_frame(1, 0);
        send_frame(2, 0);
        send_frame(3, 0);
        send_frame(4, 0);
        send_frame(4, 1);
        send_frame(4, 0);
        send_header(0);
        repeat (10) put(0, 0, 0, 0, 24'h0, 0, 0);
        repeat (2) @(posedge clk);
        #4;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
